display_mux_n: RTL and testbench

DISPLAY_MUX_N -- requirements
Module: display_mux_n

---
 rtl/display_mux_n.sv | 225 ++++++++++++++++++++++
 tb/tb_display_mux_n.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_mux_n.sv
// Multiplexed 7-segment driver for N two-digit binary fields.
// A repeated-subtraction FSM converts the fields to BCD into a shadow
// register, then commits the whole set at once to the display register.
// A scan prescaler rotates through the digits and a blink prescaler
// gates the anodes of fields selected by blink_mask.
module display_mux_n #(
    parameter int unsigned N_FIELDS  = 2,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic                    fast_clk,
    input  logic                    rst,
    input  logic [7*N_FIELDS-1:0]   fields,
    input  logic                    load,
    input  logic [N_FIELDS-1:0]     blink_mask,
    input  logic [2*N_FIELDS-1:0]   dp_mask,
    output logic                    busy,
    output logic                    done,
    output logic [2*N_FIELDS-1:0]   anode_vec,
    output logic [6:0]              cathode_vec,
    output logic                    dp
);
    localparam int unsigned ND  = 2 * N_FIELDS;
    localparam int unsigned FW  = 7 * N_FIELDS;
    localparam int unsigned DW  = 4 * ND;
    localparam int unsigned FIW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam int unsigned DIW = $clog2(ND);
    localparam int unsigned SCW = $clog2(SCAN_DIV);
    localparam int unsigned BLW = $clog2(BLINK_DIV);
    localparam logic [3:0]  DASH = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, SUB, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    latch_q, latch_d;
    logic [FIW-1:0]   fidx_q, fidx_d;
    logic [6:0]       rem_q, rem_d;
    logic [3:0]       tens_q, tens_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]    disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SCW-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DIW-1:0]   scan_idx_q, scan_idx_d;
    logic [BLW-1:0]   blink_cnt_q, blink_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [ND-1:0]    anode_q, anode_d;
    logic [6:0]       cath_q, cath_d;
    logic             dp_q, dp_d;

    logic [6:0]       field_sel;
    logic             slot_wr;
    logic [7:0]       slot_val;
    logic             scan_tick;
    logic             blink_tick;
    logic [3:0]       digit_sel;
    logic             blink_sel;
    logic             dp_sel;

    // Active-low segment pattern for a BCD digit; anything else is a dash
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0001100;
            default: seg_of = 7'b1111110;
        endcase
    endfunction

    // Pick the latched field addressed by the conversion index
    always_comb begin
        field_sel = '0;
        for (int k = 0; k < N_FIELDS; k++) begin
            if (fidx_q == FIW'(k)) field_sel = latch_q[7*k +: 7];
        end
    end

    // Conversion FSM: capture, divide by repeated subtraction, commit
    always_comb begin
        state_d  = state_q;
        latch_d  = latch_q;
        fidx_d   = fidx_q;
        rem_d    = rem_q;
        tens_d   = tens_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        slot_wr  = 1'b0;
        slot_val = '0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    latch_d = fields;
                    fidx_d  = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rem_d   = field_sel;
                tens_d  = '0;
                state_d = SUB;
            end
            SUB: begin
                if (rem_q > 7'd99) begin
                    slot_wr  = 1'b1;
                    slot_val = {DASH, DASH};
                end else if (rem_q >= 7'd10) begin
                    rem_d  = rem_q - 7'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    slot_wr  = 1'b1;
                    slot_val = {tens_q, rem_q[3:0]};
                end
                if (slot_wr) begin
                    for (int k = 0; k < N_FIELDS; k++) begin
                        if (fidx_q == FIW'(k)) shadow_d[8*k +: 8] = slot_val;
                    end
                    if (fidx_q == FIW'(N_FIELDS - 1)) begin
                        state_d = COMMIT;
                    end else begin
                        fidx_d  = fidx_q + FIW'(1);
                        state_d = LOAD;
                    end
                end
            end
            COMMIT: begin
                disp_d  = shadow_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan and blink prescalers
    always_comb begin
        scan_tick   = (scan_cnt_q == SCW'(SCAN_DIV - 1));
        scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + SCW'(1);
        scan_idx_d  = scan_idx_q;
        if (scan_tick) begin
            scan_idx_d = (scan_idx_q == DIW'(ND - 1)) ? '0 : scan_idx_q + DIW'(1);
        end
        blink_tick  = (blink_cnt_q == BLW'(BLINK_DIV - 1));
        blink_cnt_d = blink_tick ? '0 : blink_cnt_q + BLW'(1);
        blink_on_d  = blink_tick ? ~blink_on_q : blink_on_q;
    end

    // Digit drive for the incoming scan index, refreshed only on scan ticks
    always_comb begin
        digit_sel = '0;
        blink_sel = 1'b0;
        dp_sel    = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (scan_idx_d == DIW'(i)) begin
                digit_sel = disp_q[4*i +: 4];
                blink_sel = blink_mask[i/2];
                dp_sel    = dp_mask[i];
            end
        end
        anode_d = anode_q;
        cath_d  = cath_q;
        dp_d    = dp_q;
        if (scan_tick) begin
            anode_d = (blink_sel && !blink_on_q) ? {ND{1'b1}} : ~(ND'(1) << scan_idx_d);
            cath_d  = seg_of(digit_sel);
            dp_d    = ~dp_sel;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            latch_q     <= '0;
            fidx_q      <= '0;
            rem_q       <= '0;
            tens_q      <= '0;
            shadow_q    <= '0;
            disp_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            scan_cnt_q  <= '0;
            scan_idx_q  <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            anode_q     <= '1;
            cath_q      <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            latch_q     <= latch_d;
            fidx_q      <= fidx_d;
            rem_q       <= rem_d;
            tens_q      <= tens_d;
            shadow_q    <= shadow_d;
            disp_q      <= disp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            anode_q     <= anode_d;
            cath_q      <= cath_d;
            dp_q        <= dp_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign anode_vec   = anode_q;
    assign cathode_vec = cath_q;
    assign dp          = dp_q;

endmodule

// File: tb/tb_display_mux_n.sv
// Directed bench for display_mux_n with a short scan and blink period.
module tb_display_mux_n;
    localparam int unsigned NF   = 2;
    localparam int unsigned ND   = 4;
    localparam int unsigned SDIV = 4;
    localparam int unsigned BDIV = 8;

    logic              fast_clk = 1'b0;
    logic              rst;
    logic [7*NF-1:0]   fields;
    logic              load;
    logic [NF-1:0]     blink_mask;
    logic [ND-1:0]     dp_mask;
    logic              busy;
    logic              done;
    logic [ND-1:0]     anode_vec;
    logic [6:0]        cathode_vec;
    logic              dp;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned done_cnt = 0;
    logic [6:0]  exp_cath [ND];

    display_mux_n #(
        .N_FIELDS  (NF),
        .SCAN_DIV  (SDIV),
        .BLINK_DIV (BDIV)
    ) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .fields      (fields),
        .load        (load),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .busy        (busy),
        .done        (done),
        .anode_vec   (anode_vec),
        .cathode_vec (cathode_vec),
        .dp          (dp)
    );

    always #5 fast_clk = ~fast_clk;

    // Edges since reset release; both prescalers restart with it
    always @(posedge fast_clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge fast_clk);
        #1;
        if (done === 1'b1) done_cnt++;
    endtask

    // Hand table of active-low segments; 10 stands for the dash
    function automatic logic [6:0] tb_seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0001100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic int lat_of(input int v1, input int v0);
        int s;
        s = 2;
        s += (v0 > 99) ? 2 : 2 + v0 / 10;
        s += (v1 > 99) ? 2 : 2 + v1 / 10;
        return s;
    endfunction

    task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
        exp_cath[0] = tb_seg(d0);
        exp_cath[1] = tb_seg(d1);
        exp_cath[2] = tb_seg(d2);
        exp_cath[3] = tb_seg(d3);
    endtask

    // Pulse load and check latency, busy and the single-cycle done
    task automatic do_load(input string tag, input logic [6:0] f1, input logic [6:0] f0);
        int lat;
        bit got;
        fields = {f1, f0};
        load   = 1'b1;
        lat    = 0;
        got    = 1'b0;
        while (!got && lat < 200) begin
            step();
            load = 1'b0;
            lat++;
            if (lat == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
            if (done === 1'b1) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(lat_of(int'(f1), int'(f0))));
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Check anode, cathode and dp on each of the next n scan ticks
    task automatic scan_chk(input string tag, input int n_ticks);
        int seen;
        int idx;
        bit off;
        bit blank;
        logic [3:0] exp_an;
        logic [3:0] one;
        logic exp_dp;
        seen = 0;
        one  = 4'b0001;
        for (int i = 0; i < n_ticks * int'(SDIV) + int'(SDIV) && seen < n_ticks; i++) begin
            step();
            if (cyc % SDIV == 0) begin
                idx    = int'((cyc / SDIV) % ND);
                off    = (((cyc - 1) / BDIV) % 2) == 1;
                blank  = blink_mask[idx/2] && off;
                exp_an = blank ? 4'b1111 : ~(one << idx);
                exp_dp = ~dp_mask[idx];
                chk($sformatf("%s_anode_d%0d", tag, idx), 32'(anode_vec), 32'(exp_an));
                if (!blank) chk($sformatf("%s_cath_d%0d", tag, idx), 32'(cathode_vec), 32'(exp_cath[idx]));
                chk($sformatf("%s_dp_d%0d", tag, idx), 32'(dp), 32'(exp_dp));
                seen++;
            end
        end
        if (seen < n_ticks) chk({tag, "_ticks"}, 32'(seen), 32'(n_ticks));
    endtask

    initial begin
        int lat;
        int unsigned d0;
        rst        = 1'b1;
        load       = 1'b0;
        fields     = '0;
        blink_mask = '0;
        dp_mask    = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_anode", 32'(anode_vec), 32'hF);
        chk("rst_cath", 32'(cathode_vec), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        rst     = 1'b0;
        dp_mask = 4'b0100;

        // Basic conversion {59,7}; five ticks covers the 3 -> 0 wrap
        do_load("ld59_7", 7'd59, 7'd7);
        set_digits(5, 9, 0, 7);
        scan_chk("scan59_7", 5);

        // Out-of-range upper field shows dashes
        do_load("ld120_34", 7'd120, 7'd34);
        set_digits(10, 10, 3, 4);
        scan_chk("scan120_34", 4);

        // Second load while busy is dropped
        d0     = done_cnt;
        fields = {7'd12, 7'd99};
        load   = 1'b1;
        step();
        load   = 1'b0;
        lat    = 1;
        step();
        lat++;
        fields = {7'd0, 7'd0};
        load   = 1'b1;
        step();
        load   = 1'b0;
        lat++;
        chk("ign_busy", 32'(busy), 32'd1);
        while (done !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        chk("ign_latency", 32'(lat), 32'(lat_of(12, 99)));
        repeat (40) step();
        chk("ign_done_count", done_cnt - d0, 32'd1);
        set_digits(1, 2, 9, 9);
        scan_chk("scan_ign", 4);

        // Blink gating of one field at a time
        dp_mask    = 4'b0000;
        blink_mask = 2'b01;
        scan_chk("blink01", 16);
        blink_mask = 2'b10;
        scan_chk("blink10", 8);
        blink_mask = 2'b00;

        // Reset in the middle of SUB, with load in the reset cycle
        d0     = done_cnt;
        fields = {7'd90, 7'd5};
        load   = 1'b1;
        step();
        load   = 1'b0;
        repeat (4) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst  = 1'b1;
        load = 1'b1;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_anode", 32'(anode_vec), 32'hF);
        chk("abort_cath", 32'(cathode_vec), 32'h7F);
        chk("abort_dp", 32'(dp), 32'd1);
        rst  = 1'b0;
        load = 1'b0;
        for (int i = 1; i < int'(SDIV); i++) begin
            step();
            chk($sformatf("pretick_anode_%0d", i), 32'(anode_vec), 32'hF);
        end
        chk("abort_busy_after", 32'(busy), 32'd0);
        set_digits(0, 0, 0, 0);
        scan_chk("scan_abort", 4);
        repeat (20) step();
        chk("abort_no_done", done_cnt - d0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
